if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the five-stage RV32I pipeline. Holds the program counter, issues word fetches to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register (PC, instruction, valid) consumed by the ID/EX block. It absorbs downstream stalls with a one-entry skid buffer. It accepts taken-branch/jump redirects from EX, flushing wrong-path fetches, including a fetch already in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0013: instruction driven on `ifid_inst` when `ifid_valid`=0 (addi x0,x0,0).

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `imem_req` out 1: fetch request; held high with `imem_addr` stable until `imem_ack`.
- `imem_addr` out 32: word address of fetch; bits [1:0] always 0.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle; sampled only while `imem_req`=1.
- `imem_rdata` in 32: fetched instruction, valid when `imem_ack`=1.
- `stall` in 1: ID stage cannot accept a new instruction; IF/ID register holds.
- `redirect` in 1: taken branch/jump from EX; highest priority.
- `redirect_pc` in 32: target PC; bits [1:0] ignored, forced to 0.
- `ifid_pc` out 32: PC of instruction in IF/ID register.
- `ifid_inst` out 32: instruction in IF/ID register.
- `ifid_valid` out 1: IF/ID register holds a real instruction.

## Operation
- Registers: `pc` (32), IF/ID (`ifid_pc`, `ifid_inst`, `ifid_valid`), skid (`skid_pc`, `skid_inst`), FSM state.
- States: FETCH, HOLD, DISCARD.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`:
  - with `stall`=0: IF/ID <= {`pc`, `imem_rdata`, 1}, `pc` <= `pc`+4, stay in FETCH.
  - with `stall`=1: skid <= {`pc`, `imem_rdata`}, `pc` <= `pc`+4, go to HOLD.
- FETCH with no ack and `stall`=0: IF/ID <= {`ifid_pc`, `NOP_INST`, 0}, i.e. a bubble. With `stall`=1 the IF/ID register holds.
- HOLD: `imem_req`=0. IF/ID holds while `stall`=1. When `stall`=0: IF/ID <= {skid, 1}, go to FETCH.
- DISCARD: `imem_req`=1 with the old address until `imem_ack`. The returned data is dropped and the state goes to FETCH with the new `pc`. IF/ID stays a bubble.
- `redirect`=1 overrides `stall` and every other event in every state:
  - `pc` <= {`redirect_pc`[31:2], 2'b00}, skid invalidated, IF/ID <= {`ifid_pc`, `NOP_INST`, 0}.
  - From FETCH with `imem_req`=1 and no ack, or from DISCARD without ack: go to DISCARD.
  - From FETCH with ack in the same cycle, or from HOLD: go to FETCH, and the acked data is dropped.
- A redirect while in DISCARD updates `pc` again and stays in DISCARD until the ack.
- `pc`+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Only one request is ever outstanding; `imem_addr` never changes while `imem_req`=1 and no ack.

## Timing
- Reset (asynchronous, immediate):
  - `pc`=`RESET_PC`, state=FETCH.
  - `ifid_valid`=0, `ifid_inst`=`NOP_INST`, `ifid_pc`=`RESET_PC`.
  - Skid invalid.
  - `imem_req`=0 while `RST`=1, then 1 from the first cycle after deassertion.
- Reset mid-request aborts the fetch; a late `imem_ack` in the first post-reset cycle is treated as the ack of the new request to `RESET_PC` (memory must also reset).
- `imem_req` and `imem_addr` are decoded from registered state and `pc`, with no combinational path from `imem_ack`, `stall` or `redirect`.
- Latency: instruction appears on `ifid_*` one edge after the ack edge. With a zero-wait memory (ack in the same cycle as req), throughput is 1 instruction/cycle.
- Redirect to first valid target instruction: minimum 2 cycles (redirect edge, then ack edge). Add the remaining memory latency when in DISCARD.

## Test plan
- Reset, zero-wait memory returning `addr`: `ifid_pc` = 0,4,8,... on consecutive cycles, `ifid_valid`=1 from cycle 2, `ifid_inst`=`ifid_pc`.
- 3-cycle ack latency: `imem_addr` stays 0x0 for 3 cycles, then `ifid_valid` pulses once per 3 cycles with pc 0x0, 0x4, 0x8.
- `stall`=1 asserted in the cycle of the ack for pc 0x8, held 4 cycles:
  - `ifid` holds pc 0x4 and `imem_req`=0 during HOLD.
  - After release, `ifid_pc`=0x8 then 0xC, with no duplicate or lost instruction.
- `redirect`=1 to 0x1003 while a 3-cycle fetch of 0x10 is in flight:
  - The 0x10 data is dropped and the next request is to 0x1000.
  - First valid `ifid_pc`=0x1000, with bubbles in between.
- `redirect` and `stall` together in HOLD: skid discarded, `ifid_valid`=0, next fetch from redirect target. Then set `pc`=0xFFFF_FFFC by redirect and confirm the next address is 0x0.

Source files
------------

// File: rtl/if_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : if_fetch_stage
//  Brief    : RV32I instruction-fetch stage. Owns the PC, issues word fetches
//             over a req/ack handshake, feeds the IF/ID pipeline register,
//             absorbs one downstream stall via a skid entry and handles EX
//             redirects (including squashing a fetch already in flight).
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction memory handshake
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // pipeline control
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  // IF/ID pipeline register
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid
);

  // Reset PC forced to a word boundary so imem_addr[1:0] is always zero.
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  // FETCH   : request outstanding at pc
  // HOLD    : fetched word parked in skid while ID is stalled, no request
  // DISCARD : wrong-path request still in flight, its data will be dropped
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] discard_addr;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        skid_valid;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsbs;

  // Sequential PC increment wraps naturally at 2^32.
  assign pc_plus4        = pc + 32'd4;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Request decode depends only on registered state, pc and reset. While in
  // DISCARD the old address is kept on the bus until the memory answers.
  assign imem_req  = (state != S_HOLD) && !RST;
  assign imem_addr = (state == S_DISCARD) ? discard_addr : pc;

  // Control FSM and program counter; redirect overrides every other event.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_FETCH;
      pc           <= RESET_PC_W;
      discard_addr <= RESET_PC_W;
    end else if (redirect) begin
      pc <= redirect_target;
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            // Acked word belongs to the wrong path: drop it, fetch target.
            state <= S_FETCH;
          end else begin
            // Request still open: keep its address until the ack arrives.
            state        <= S_DISCARD;
            discard_addr <= pc;
          end
        end
        S_DISCARD: begin
          // discard_addr keeps the original in-flight address.
          state <= imem_ack ? S_FETCH : S_DISCARD;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            pc <= pc_plus4;
            if (stall) begin
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            state <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem_ack) begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  // IF/ID pipeline register and skid entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ifid_pc    <= RESET_PC_W;
      ifid_inst  <= NOP_INST;
      ifid_valid <= 1'b0;
      skid_pc    <= RESET_PC_W;
      skid_inst  <= NOP_INST;
      skid_valid <= 1'b0;
    end else if (redirect) begin
      // Squash: bubble into ID regardless of stall, forget any parked word.
      ifid_inst  <= NOP_INST;
      ifid_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack && !stall) begin
            ifid_pc    <= pc;
            ifid_inst  <= imem_rdata;
            ifid_valid <= 1'b1;
          end else if (imem_ack) begin
            // ID still busy with the previous word: park the new one.
            skid_pc    <= pc;
            skid_inst  <= imem_rdata;
            skid_valid <= 1'b1;
          end else if (!stall) begin
            // Nothing arrived and ID consumed its word: insert a bubble.
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_pc    <= skid_pc;
            ifid_inst  <= skid_valid ? skid_inst : NOP_INST;
            ifid_valid <= skid_valid;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          // DISCARD: IF/ID already holds a bubble from the redirect edge.
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Brief    : Directed self-checking bench for if_fetch_stage with a
//             latency-programmable memory model and an expected-instruction
//             scoreboard drained as ID consumes instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic        ifid_valid;

  int          n_vec = 0;
  int          n_bad = 0;
  int          lat = 1;
  logic [31:0] key = 32'd0;
  bit          mon_en = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb_q[$];

  // memory model state
  int          mem_cnt = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_pc     (ifid_pc),
    .ifid_inst   (ifid_inst),
    .ifid_valid  (ifid_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    sb_q.push_back({pc, pc ^ key});
  endtask

  // Memory: acks after lat cycles of request, returns addr ^ key; also
  // verifies that an un-acked request keeps its address.
  always @(negedge clk) begin
    if (rst) begin
      imem_ack = 1'b0;
      mem_cnt  = 0;
      pend     = 1'b0;
    end else begin
      if (pend) begin
        check("req_held", {31'd0, imem_req}, 32'd1);
        check("addr_stable", imem_addr, pend_addr);
      end
      if (imem_req) begin
        if (mem_cnt == lat - 1) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ key;
          mem_cnt    = 0;
        end else begin
          imem_ack = 1'b0;
          mem_cnt  = mem_cnt + 1;
        end
      end else begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
    end
  end

  // Scoreboard: an instruction is consumed when valid, not stalled, not flushed.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst && ifid_valid === 1'b1 && !stall && !redirect) begin
      check("sb_entry_ready", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("ifid_pc", ifid_pc, e.pc);
        check("ifid_inst", ifid_inst, e.inst);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    stall  = 1'b0;
    redirect = 1'b0;
    #1;
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_inst", ifid_inst, NOP);
    check("rst_pc", ifid_pc, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'd0);
    check("post_rst_valid", {31'd0, ifid_valid}, 32'd0);
    mon_en = 1'b1;
  endtask

  task automatic end_phase();
    mon_en = 1'b0;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    // Phase 1: zero-wait memory, one instruction per cycle, inst == pc.
    lat = 1;
    key = 32'd0;
    for (int i = 0; i < 8; i++) push(32'(i * 4));
    do_reset();
    repeat (9) step();
    end_phase();

    // Phase 2: 3-cycle memory latency.
    lat = 3;
    key = 32'hABCD_0000;
    push(32'h0); push(32'h4); push(32'h8);
    do_reset();
    step();
    check("lat3_addr_c1", imem_addr, 32'h0);
    step();
    check("lat3_addr_c2", imem_addr, 32'h0);
    check("lat3_req_c2", {31'd0, imem_req}, 32'd1);
    step();
    check("lat3_addr_next", imem_addr, 32'h4);
    step();
    check("lat3_bubble_valid", {31'd0, ifid_valid}, 32'd0);
    check("lat3_bubble_inst", ifid_inst, NOP);
    check("lat3_bubble_pc", ifid_pc, 32'h0);
    repeat (6) step();
    end_phase();

    // Phase 3: stall in the ack cycle of pc 0x8, held 4 cycles.
    lat = 1;
    key = 32'h5500_0000;
    push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_ifid_pc", ifid_pc, 32'h4);
      check("hold_ifid_valid", {31'd0, ifid_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    check("unhold_ifid_pc", ifid_pc, 32'h8);
    check("unhold_addr", imem_addr, 32'hC);
    repeat (3) step();
    end_phase();

    // Phase 4: redirect to 0x1003 while a 3-cycle fetch of 0x10 is in flight.
    lat = 3;
    key = 32'h0F0F_0000;
    push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h1000);
    do_reset();
    repeat (13) step();
    check("inflight_addr", imem_addr, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1003;
    step();
    redirect = 1'b0;
    check("discard_req", {31'd0, imem_req}, 32'd1);
    check("discard_addr", imem_addr, 32'h10);
    check("discard_valid", {31'd0, ifid_valid}, 32'd0);
    step();
    check("after_discard_addr", imem_addr, 32'h1000);
    repeat (4) step();
    end_phase();

    // Phase 5: redirect with stall in HOLD, then wrap from 0xFFFF_FFFC.
    lat = 1;
    key = 32'h3300_0000;
    push(32'h0); push(32'h2000); push(32'hFFFF_FFFC); push(32'h0);
    do_reset();
    step();
    step();
    stall = 1'b1;
    step();
    check("p5_hold_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    check("hold_redir_valid", {31'd0, ifid_valid}, 32'd0);
    check("hold_redir_inst", ifid_inst, NOP);
    check("hold_redir_req", {31'd0, imem_req}, 32'd1);
    check("hold_redir_addr", imem_addr, 32'h2000);
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    check("wrap_target_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_bubble", {31'd0, ifid_valid}, 32'd0);
    step();
    check("wrap_next_addr", imem_addr, 32'h0);
    check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    step();
    step();
    end_phase();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
